// File: rtl/miner_nonce_engine.sv
// Nonce search sequencer for NUM_CH external double-SHA256 cores. A batch costs DISPATCH + core latency + CHECK.
// No backpressure: it waits for every started core to report; optional 48-bit hash_count under MINER_HASHRATE_CNT_EN.
module miner_nonce_engine #(
    parameter int NUM_CH       = 4,
    parameter int NONCE_W      = 32,
    parameter int HDR_W        = 640,
    parameter bit STOP_ON_FIND = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [HDR_W-1:0]          header_in,
    input  logic [255:0]              target,
    input  logic [NONCE_W-1:0]        nonce_first,
    input  logic [NONCE_W-1:0]        nonce_last,
    output logic [NUM_CH-1:0]         core_start,
    output logic [HDR_W-1:0]          core_header,
    output logic [NUM_CH*NONCE_W-1:0] core_nonce,
    input  logic [NUM_CH-1:0]         core_done,
    input  logic [NUM_CH*256-1:0]     core_hash,
    output logic                      busy,
    output logic                      found,
    output logic [NONCE_W-1:0]        found_nonce,
    output logic [255:0]              found_hash,
    output logic                      exhausted,
    output logic                      led
`ifdef MINER_HASHRATE_CNT_EN
    ,
    output logic [47:0]               hash_count
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_WAIT, S_CHECK, S_FOUND, S_EXHAUSTED} state_t;

    localparam logic [HDR_W-1:0] HDR_KEEP = {{(HDR_W-NONCE_W){1'b1}}, {NONCE_W{1'b0}}};

    state_t                   state, state_nxt;
    logic [NONCE_W-1:0]       base, last_q;
    logic [255:0]             target_q;
    logic [NUM_CH-1:0]        start_mask, done_mask, done_seen, launch, hit;
    logic [NUM_CH-1:0][255:0] hash_q;
    logic [NONCE_W:0]         cand, base_step;
    logic [NONCE_W-1:0]       win_nonce;
    logic [255:0]             win_hash;
    logic                     can_start, range_bad, more, any_hit;

    assign can_start = (state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUSTED);
    assign range_bad = nonce_first > nonce_last;
    assign base_step = {1'b0, base} + (NONCE_W+1)'(NUM_CH);
    // The carry bit catches a batch that would wrap past the top of the nonce space.
    assign more      = !base_step[NONCE_W] && (base_step[NONCE_W-1:0] <= last_q);
    assign done_seen = done_mask | (core_done & start_mask);
    assign any_hit   = |hit;

    always_comb begin
        launch    = '0;
        hit       = '0;
        cand      = '0;
        win_nonce = '0;
        win_hash  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand      = {1'b0, base} + (NONCE_W+1)'(i);
            launch[i] = !cand[NONCE_W] && (cand[NONCE_W-1:0] <= last_q);
            hit[i]    = start_mask[i] && (hash_q[i] < target_q);
        end
        // Descending scan so the lowest-index hit is the one left standing.
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (hit[i]) begin
                win_nonce = base + NONCE_W'(i);
                win_hash  = hash_q[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_FOUND, S_EXHAUSTED:
                    if (start) state_nxt = range_bad ? S_EXHAUSTED : S_DISPATCH;
                S_DISPATCH: state_nxt = S_WAIT;
                S_WAIT:     if (done_seen == start_mask) state_nxt = S_CHECK;
                S_CHECK: begin
                    if (any_hit && STOP_ON_FIND) state_nxt = S_FOUND;
                    else if (more)               state_nxt = S_DISPATCH;
                    else                         state_nxt = S_EXHAUSTED;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        core_start = '0;
        core_nonce = '0;
        busy       = 1'b0;
        led        = found;
        case (state)
            S_DISPATCH: begin
                core_start = launch;
                busy       = 1'b1;
                for (int i = 0; i < NUM_CH; i++)
                    core_nonce[i*NONCE_W +: NONCE_W] = base + NONCE_W'(i);
            end
            S_WAIT, S_CHECK: busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base        <= '0;
            last_q      <= '0;
            target_q    <= '0;
            core_header <= '0;
            start_mask  <= '0;
            done_mask   <= '0;
            hash_q      <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            exhausted   <= 1'b0;
        end else if (!abort) begin
            case (state)
                S_IDLE, S_FOUND, S_EXHAUSTED: begin
                    if (start) begin
                        core_header <= header_in & HDR_KEEP;
                        target_q    <= target;
                        last_q      <= nonce_last;
                        base        <= nonce_first;
                        found       <= 1'b0;
                        found_nonce <= '0;
                        found_hash  <= '0;
                        exhausted   <= range_bad;
                    end
                end
                S_DISPATCH: begin
                    start_mask <= launch;
                    done_mask  <= '0;
                end
                S_WAIT: begin
                    done_mask <= done_seen;
                    for (int i = 0; i < NUM_CH; i++)
                        if (core_done[i] && start_mask[i]) hash_q[i] <= core_hash[i*256 +: 256];
                end
                S_CHECK: begin
                    if (any_hit && !found) begin
                        found       <= 1'b1;
                        found_nonce <= win_nonce;
                        found_hash  <= win_hash;
                    end
                    if (!(any_hit && STOP_ON_FIND)) begin
                        if (more) base      <= base_step[NONCE_W-1:0];
                        else      exhausted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MINER_HASHRATE_CNT_EN
    logic [47:0] pop;
    logic [48:0] cnt_sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) pop = pop + 48'(core_done[i] & start_mask[i]);
        cnt_sum = {1'b0, hash_count} + {1'b0, pop};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                            hash_count <= '0;
        else if (!abort && start && can_start)   hash_count <= '0;
        else if (!abort && state == S_WAIT)      hash_count <= cnt_sum[48] ? '1 : cnt_sum[47:0];
    end
`endif

endmodule

// File: tb/tb_miner_nonce_engine.sv
// Scoreboarded bench: two engines (stop-on-find and search-on), each with a randomized core model and reference predictor.
module tb_miner_nonce_engine;
    localparam int N  = 4;
    localparam int NW = 32;
    localparam int HW = 640;

    typedef struct packed {
        logic [N-1:0]  mask;
        logic [NW-1:0] base;
    } batch_t;

    typedef struct packed {
        logic          found;
        logic [NW-1:0] nonce;
        logic [255:0]  hash;
        logic          exh;
        logic [47:0]   cnt;
    } result_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int passes   = 0;
    int done_cnt = 0;

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam bit STOP = (k == 0);

        logic                reset_n, start, abort;
        logic [HW-1:0]       header_in, exp_hdr, core_header;
        logic [255:0]        target, found_hash;
        logic [NW-1:0]       nonce_first, nonce_last, found_nonce;
        logic [N-1:0]        core_start, core_done, batch_mask;
        logic [N*NW-1:0]     core_nonce;
        logic [N*256-1:0]    core_hash;
        logic                busy, found, exhausted, led;
        logic                track, slow, prev_active;
`ifdef MINER_HASHRATE_CNT_EN
        logic [47:0]         hash_count;
`endif

        miner_nonce_engine #(.NUM_CH(N), .NONCE_W(NW), .HDR_W(HW), .STOP_ON_FIND(STOP)) dut (
            .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
            .header_in(header_in), .target(target),
            .nonce_first(nonce_first), .nonce_last(nonce_last),
            .core_start(core_start), .core_header(core_header), .core_nonce(core_nonce),
            .core_done(core_done), .core_hash(core_hash),
            .busy(busy), .found(found), .found_nonce(found_nonce), .found_hash(found_hash),
            .exhausted(exhausted), .led(led)
`ifdef MINER_HASHRATE_CNT_EN
            , .hash_count(hash_count)
`endif
        );

        batch_t        bq[$];
        result_t       rq[$];
        logic [NW-1:0] hits[$];
        logic          pend [N];
        int            lat  [N];
        logic [NW-1:0] pn   [N];

        task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
            checks++;
            if (act === exp) passes++;
            else $display("FAIL %s inst%0d: got %h expected %h", name, k, act, exp);
        endtask

        function automatic logic is_hit(input logic [NW-1:0] n);
            foreach (hits[j]) if (hits[j] == n) return 1'b1;
            return 1'b0;
        endfunction

        // Hits sit just below the target; one nonce in three misses by landing exactly on it.
        function automatic logic [255:0] hash_of(input logic [NW-1:0] n);
            if (is_hit(n)) return target - 256'(n[7:0]) - 256'd1;
            if ((n % 32'd3) == 32'd0) return target;
            return target + 256'(n);
        endfunction

        task automatic new_target();
            for (int j = 0; j < 8; j++) target[j*32 +: 32] = $urandom();
            target[255:240] = 16'h00ff;
        endtask

        task automatic predict(input logic [NW-1:0] first, input logic [NW-1:0] last);
            longint unsigned b, lst;
            result_t r;
            batch_t  bt;
            logic    hit_here;
            r   = '0;
            b   = 64'(first);
            lst = 64'(last);
            if (first > last) begin
                r.exh = 1'b1;
                rq.push_back(r);
                return;
            end
            while (1'b1) begin
                bt.mask  = '0;
                bt.base  = b[NW-1:0];
                hit_here = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (b + 64'(i) <= lst) begin
                        bt.mask[i] = 1'b1;
                        r.cnt = r.cnt + 48'd1;
                        if (is_hit(NW'(b + 64'(i)))) begin
                            hit_here = 1'b1;
                            if (!r.found) begin
                                r.found = 1'b1;
                                r.nonce = NW'(b + 64'(i));
                                r.hash  = hash_of(r.nonce);
                            end
                        end
                    end
                end
                bq.push_back(bt);
                if (hit_here && STOP) break;
                if (b + 64'(N) > lst) begin
                    r.exh = 1'b1;
                    break;
                end
                b = b + 64'(N);
            end
            rq.push_back(r);
        endtask

        task automatic run(input logic [NW-1:0] first, input logic [NW-1:0] last, input logic poke);
            for (int j = 0; j < HW/32; j++) header_in[j*32 +: 32] = $urandom();
            exp_hdr     = {header_in[HW-1:NW], {NW{1'b0}}};
            nonce_first = first;
            nonce_last  = last;
            predict(first, last);
            @(posedge clock); #1 start = 1'b1;
            @(posedge clock); #1 start = 1'b0;
            if (poke) begin
                @(posedge clock); #1 start = 1'b1; nonce_first = first + 32'd1000;
                @(posedge clock); #1 start = 1'b0; nonce_first = first;
            end
            for (int c = 0; c < 3000; c++) begin
                if (rq.size() == 0 && bq.size() == 0) break;
                @(posedge clock);
            end
            if (rq.size() != 0 || bq.size() != 0) begin
                checks++;
                $display("FAIL run_timeout inst%0d: %0d batches and %0d results still pending", k, bq.size(), rq.size());
                bq.delete();
                rq.delete();
            end
            repeat (3) @(posedge clock);
        endtask

        // Core model: reacts at negedges, also fires stray done pulses on channels the batch left idle.
        initial begin
            core_done  = '0;
            core_hash  = '0;
            batch_mask = '0;
            for (int i = 0; i < N; i++) begin
                pend[i] = 1'b0;
                lat[i]  = 0;
                pn[i]   = '0;
            end
            forever begin
                @(negedge clock);
                core_done = '0;
                for (int i = 0; i < N; i++) begin
                    if (pend[i]) begin
                        if (lat[i] == 0) begin
                            core_done[i] = 1'b1;
                            core_hash[i*256 +: 256] = hash_of(pn[i]);
                            pend[i] = 1'b0;
                        end else begin
                            lat[i] = lat[i] - 1;
                        end
                    end
                end
                if (|core_start) batch_mask = core_start;
                for (int i = 0; i < N; i++) begin
                    if (core_start[i]) begin
                        pend[i] = 1'b1;
                        pn[i]   = core_nonce[i*NW +: NW];
                        lat[i]  = slow ? 2 : int'($urandom_range(0, 4));
                    end
                    if (!batch_mask[i] && !core_done[i] && $urandom_range(0, 7) == 0) begin
                        core_done[i] = 1'b1;
                        core_hash[i*256 +: 256] = '0;
                    end
                end
            end
        end

        initial begin
            batch_t        eb;
            result_t       er;
            logic [N*NW-1:0] mx, en;
            prev_active = 1'b0;
            forever begin
                @(negedge clock);
                if (track && |core_start) begin
                    if (bq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_dispatch inst%0d: mask %b with nothing expected", k, core_start);
                    end else begin
                        eb = bq.pop_front();
                        mx = '0;
                        en = '0;
                        for (int i = 0; i < N; i++) begin
                            if (eb.mask[i]) begin
                                mx[i*NW +: NW] = '1;
                                en[i*NW +: NW] = eb.base + NW'(i);
                            end
                        end
                        chk("dispatch_mask", 256'(core_start), 256'(eb.mask));
                        chk("dispatch_nonce", 256'(core_nonce & mx), 256'(en));
                    end
                end
                if (track && prev_active && !busy && (found || exhausted)) begin
                    if (rq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_result inst%0d: found %b exhausted %b", k, found, exhausted);
                    end else begin
                        er = rq.pop_front();
                        chk("found", 256'(found), 256'(er.found));
                        chk("led", 256'(led), 256'(er.found));
                        chk("exhausted", 256'(exhausted), 256'(er.exh));
                        chk("header_zeroed", 256'(core_header === exp_hdr), 256'd1);
                        if (er.found) begin
                            chk("found_nonce", 256'(found_nonce), 256'(er.nonce));
                            chk("found_hash", found_hash, er.hash);
                        end
`ifdef MINER_HASHRATE_CNT_EN
                        chk("hash_count", 256'(hash_count), 256'(er.cnt));
`endif
                    end
                end
                prev_active = busy || start;
            end
        end

        initial begin
            int          pulses;
            logic [NW-1:0] f, l;
            longint      ln;
            track = 1'b1; slow = 1'b0;
            reset_n = 1'b0; start = 1'b0; abort = 1'b0;
            header_in = '0; exp_hdr = '0; target = '0;
            nonce_first = '0; nonce_last = '0;
            #12;
            chk("rst_busy", 256'(busy), 256'd0);
            chk("rst_found", 256'(found), 256'd0);
            chk("rst_exhausted", 256'(exhausted), 256'd0);
            chk("rst_led", 256'(led), 256'd0);
            chk("rst_core_start", 256'(core_start), 256'd0);
            chk("rst_core_nonce", 256'(core_nonce), 256'd0);
            chk("rst_found_hash", found_hash, 256'd0);
            chk("rst_header", 256'(core_header == '0), 256'd1);
            @(posedge clock); #1 reset_n = 1'b1;

            new_target();
            hits.delete(); hits.push_back(32'd5);
            run(32'd0, 32'd7, 1'b0);
            @(posedge clock); #1 abort = 1'b1;
            @(posedge clock); #1 abort = 1'b0;
            chk("abort_keeps_found", 256'(found), 256'd1);
            chk("abort_keeps_nonce", 256'(found_nonce), 256'd5);

            hits.delete();
            run(32'd0, 32'd5, 1'b0);
            run(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
            hits.push_back(32'd2); hits.push_back(32'd3); hits.push_back(32'd6);
            new_target();
            run(32'd0, 32'd9, 1'b0);
            hits.delete();
            run(32'd0, 32'd9, 1'b1);
            run(32'd10, 32'd3, 1'b0);
            hits.push_back(32'd7);
            run(32'd7, 32'd7, 1'b0);

            for (int r = 0; r < 10; r++) begin
                new_target();
                f  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + NW'($urandom_range(0, 15))
                                                 : NW'($urandom_range(1, 100000));
                ln = longint'(f) + longint'($urandom_range(0, 13));
                if (ln > 64'sh0_FFFF_FFFF) ln = 64'sh0_FFFF_FFFF;
                l  = (r % 5 == 4) ? f - 32'd1 : NW'(ln);
                hits.delete();
                for (int h = 0; h < int'($urandom_range(0, 2)); h++) hits.push_back(f + NW'($urandom_range(0, 13)));
                run(f, l, 1'b0);
            end

            track = 1'b0;
            hits.delete();
            nonce_first = 32'd0; nonce_last = 32'd99;
            @(posedge clock); #1 start = 1'b1;
            @(posedge clock); #1 start = 1'b0;
            repeat (5) @(posedge clock);
            #1 abort = 1'b1;
            @(posedge clock); #1 abort = 1'b0;
            chk("abort_idle", 256'(busy), 256'd0);
            pulses = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clock); #1;
                if (|core_start || busy) pulses++;
            end
            chk("abort_quiet", 256'(pulses), 256'd0);

            slow = 1'b1;
            for (int h = 0; h < 4; h++) hits.push_back(NW'(h));
            new_target();
            @(posedge clock); #1 start = 1'b1;
            @(posedge clock); #1 start = 1'b0;
            @(posedge clock); #2 reset_n = 1'b0;
            #1;
            chk("mid_rst_busy", 256'(busy), 256'd0);
            chk("mid_rst_found", 256'(found), 256'd0);
            chk("mid_rst_exhausted", 256'(exhausted), 256'd0);
            chk("mid_rst_core_start", 256'(core_start), 256'd0);
            chk("mid_rst_core_nonce", 256'(core_nonce), 256'd0);
            chk("mid_rst_header", 256'(core_header == '0), 256'd1);
            @(posedge clock); #2 reset_n = 1'b1;
            repeat (12) @(posedge clock);
            #1;
            chk("stale_done_found", 256'(found), 256'd0);
            chk("stale_done_busy", 256'(busy), 256'd0);
            chk("stale_done_led", 256'(led), 256'd0);
            slow  = 1'b0;
            track = 1'b1;
            hits.delete(); hits.push_back(32'd5);
            run(32'd0, 32'd7, 1'b0);
            done_cnt++;
        end
    end

    initial begin
        for (int c = 0; c < 60000 && done_cnt < 2; c++) @(posedge clock);
        if (done_cnt < 2) begin
            checks++;
            $display("FAIL global_timeout: %0d of 2 sequences finished", done_cnt);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/miner_nonce_engine.md
MINER_NONCE_ENGINE -- requirements
Module: miner_nonce_engine

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of external double-SHA256 hash cores driven in parallel (1..16).
REQ-002 The block SHALL have parameter NONCE_W, default 32, meaning the nonce width in bits.
REQ-003 The block SHALL have parameter HDR_W, default 640, meaning the block header width in bits; the nonce occupies header bits [NONCE_W-1:0].
REQ-004 The block SHALL have parameter STOP_ON_FIND, default 1: 1 halts on the first hit, 0 records the hit and keeps searching.
REQ-005 Ports (name  direction  width  meaning):
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches header_in, target, nonce_first, nonce_last; ignored unless IDLE, EXHAUSTED or FOUND.
- abort  in  1  returns the engine to IDLE next cycle.
- header_in  in  HDR_W  header template.
- target  in  256  difficulty target.
- nonce_first, nonce_last  in  NONCE_W  inclusive search range.
- core_start  out  NUM_CH  per-channel one-cycle start pulse.
- core_header  out  HDR_W  latched header with nonce field zeroed, shared by all channels.
- core_nonce  out  NUM_CH*NONCE_W  nonce for channel i at slice i.
- core_done  in  NUM_CH  per-channel one-cycle completion pulse.
- core_hash  in  NUM_CH*256  hash for channel i, valid with core_done[i].
- busy  out  1  high in DISPATCH, WAIT or CHECK.
- found  out  1  sticky hit flag.
- found_nonce  out  NONCE_W  nonce of the recorded hit.
- found_hash  out  256  hash of the recorded hit.
- exhausted  out  1  range finished without a halting hit.
- led  out  1  equals found.

Function
REQ-006 The FSM SHALL have states IDLE, DISPATCH, WAIT, CHECK, FOUND and EXHAUSTED.
REQ-007 On start, the block SHALL latch all inputs, set base=nonce_first, clear found and exhausted, and enter DISPATCH on the next edge.
REQ-008 In DISPATCH, the block SHALL, for one cycle, drive core_nonce[i]=base+i and assert core_start[i] only for channels with base+i<=nonce_last and no NONCE_W overflow; the block SHALL then enter WAIT.
REQ-009 In WAIT, the block SHALL OR core_done into a done mask; core_done on unstarted channels SHALL be ignored; when done mask equals start mask, the block SHALL enter CHECK.
REQ-010 When core_done[i] is asserted, the block SHALL register core_hash[i]; a hit is registered hash < target, unsigned 256-bit compare.
REQ-011 In CHECK, the lowest-index hit channel SHALL win; if it exists and found=0, the block SHALL set found, found_nonce and found_hash; later hits SHALL NOT overwrite them.
REQ-012 From CHECK, the block SHALL enter FOUND if a hit exists and STOP_ON_FIND=1.
REQ-013 Otherwise, from CHECK, the block SHALL enter EXHAUSTED if base+NUM_CH>nonce_last or base+NUM_CH overflows NONCE_W (full range wrap), else set base+=NUM_CH and enter DISPATCH.
REQ-014 On EXHAUSTED entry, exhausted SHALL be 1 and found SHALL keep its value.
REQ-015 If nonce_first>nonce_last at start, the block SHALL enter EXHAUSTED with no core_start pulse.
REQ-016 abort SHALL take priority over start and over all transitions; it clears no result outputs.
REQ-017 start while busy SHALL be ignored.
REQ-018 core_start SHALL be 0 in every state except DISPATCH.

Reset
REQ-019 When reset_n=0, the block SHALL asynchronously force: state IDLE, base 0, masks 0, core_start 0, core_nonce 0, core_header 0, busy 0, found 0, found_nonce 0, found_hash 0, exhausted 0, led 0.
REQ-020 A reset mid-search SHALL discard the batch; core_done arriving after release SHALL be ignored in IDLE.

Configuration
REQ-021 With MINER_HASHRATE_CNT_EN defined, the block SHALL add output hash_count (48 bits): cleared by reset and start, incremented by popcount(core_done & start mask) each cycle in WAIT, saturating at all-ones.
REQ-022 Without MINER_HASHRATE_CNT_EN, the hash_count port and counter SHALL be absent, with no other behavioural change.

Verification
REQ-023 NUM_CH=4, range 0..7, core model returns hash=target+1 for all nonces except nonce 5 (hash 0) -> two DISPATCH rounds, found=1, found_nonce=5, FOUND state, led=1.
REQ-024 NUM_CH=4, range 0..5, no hit -> second batch starts only channels 0,1 (nonces 4,5); exhausted=1, found=0.
REQ-025 Range 0xFFFFFFFE..0xFFFFFFFF, NUM_CH=4 -> only channels 0,1 start; no wrap to 0; exhausted=1.
REQ-026 STOP_ON_FIND=0, hits at nonces 2 and 3 in one batch and 6 later -> found_nonce=2, search completes to EXHAUSTED with found=1.
REQ-027 reset_n pulsed low during WAIT -> all outputs 0 immediately; stale core_done ignored; a new start runs normally.
REQ-028 MINER_HASHRATE_CNT_EN defined, range 0..9, NUM_CH=4, no hit -> hash_count=10 at EXHAUSTED.
